// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - shared types and constants for the pixel array controller
// Purpose: state encoding, DATA bus width, pixel count and the read-select decode
//          used by pixel_ctrl and pixel_ctrl_cnt.
// Ports:   none (package).
package pixel_ctrl_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_PIX   = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 16;
  localparam int NUM_CODES = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_TURN,
    S_SETTLE,
    S_HOLD
  } state_t;

  // One-hot READ select for a pixel index.
  function automatic logic [NUM_PIX-1:0] read_sel(input logic [IDX_W-1:0] idx);
    return NUM_PIX'(1) << idx;
  endfunction

endpackage

// File: rtl/pixel_ctrl_cnt.sv
// rtl/pixel_ctrl_cnt.sv - 16-bit up/down phase counter with load and terminal flag
// Purpose: times every phase of the pixel controller; loaded on phase entry,
//          stepped while enabled, terminal when the count equals limit.
// Ports:   clk, reset_n   - clock, synchronous active-low reset
//          load, load_val - load the counter (takes priority over en)
//          en, up         - step enable and direction
//          limit          - value at which term is flagged
//          count, term    - current count and terminal flag
module pixel_ctrl_cnt
  import pixel_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == limit);

endmodule

// File: rtl/pixel_ctrl.sv
// rtl/pixel_ctrl.sv - erase/expose/convert/readout sequencer for a 4-pixel array
// Purpose: runs one frame per start: ERASE, EXPOSE, a 256-step ramp conversion
//          driving DATA, a one-cycle bus turnaround, then reads the four latched
//          pixel codes out through a valid/ready handshake.
// Ports:   clk, reset_n                - clock, synchronous active-low reset
//          start                       - frame request, honoured only in IDLE
//          ERASE, EXPOSE, PIX_RESET    - array phase controls
//          CONVERT                     - ramp generator enable
//          READ[3:0]                   - one-hot pixel read select
//          data_oe, data_out, data_in  - shared DATA bus drive/sense
//          pix_data, pix_idx           - captured pixel code and its index
//          pix_valid, pix_ready        - output handshake
//          frame_done                  - one-cycle pulse after pixel 3 accepted
module pixel_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  parameter int C_SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               ERASE,
  output logic               EXPOSE,
  output logic               PIX_RESET,
  output logic               CONVERT,
  output logic [NUM_PIX-1:0] READ,
  output logic               data_oe,
  output logic [DATA_W-1:0]  data_out,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  pix_data,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               frame_done
);

  state_t state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               erase_q, erase_d;
  logic               expose_q, expose_d;
  logic               pix_reset_q, pix_reset_d;
  logic               convert_q, convert_d;
  logic [NUM_PIX-1:0] read_q, read_d;
  logic               data_oe_q, data_oe_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic [DATA_W-1:0]  pix_data_q, pix_data_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               pix_valid_q, pix_valid_d;
  logic               frame_done_q, frame_done_d;

  logic             cnt_load, cnt_en, cnt_up, cnt_term;
  logic [CNT_W-1:0] cnt_val, cnt_limit, cnt_count;

  // Phase counters load "length - 1" and count down to zero, except the
  // conversion ramp which counts up 0..255 so the count is the bus value.
  assign cnt_up    = (state_q == S_CONVERT);
  assign cnt_limit = cnt_up ? CNT_W'(NUM_CODES - 1) : '0;

  pixel_ctrl_cnt u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .limit    (cnt_limit),
    .count    (cnt_count),
    .term     (cnt_term)
  );

  // Outputs are computed for the state being entered so that every output
  // is a flop and changes on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    erase_d      = 1'b0;
    expose_d     = 1'b0;
    pix_reset_d  = 1'b0;
    convert_d    = 1'b0;
    read_d       = '0;
    data_oe_d    = 1'b0;
    data_out_d   = '0;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_valid_d  = pix_valid_q;
    frame_done_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_val      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ERASE;
          cnt_load    = 1'b1;
          cnt_val     = CNT_W'(C_ERASE - 1);
          erase_d     = 1'b1;
          pix_reset_d = 1'b1;
        end
      end
      S_ERASE: begin
        if (cnt_term) begin
          state_d  = S_EXPOSE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(C_EXPOSE - 1);
          expose_d = 1'b1;
        end else begin
          cnt_en      = 1'b1;
          erase_d     = 1'b1;
          pix_reset_d = 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_term) begin
          state_d   = S_CONVERT;
          cnt_load  = 1'b1;
          convert_d = 1'b1;
          data_oe_d = 1'b1;
        end else begin
          cnt_en   = 1'b1;
          expose_d = 1'b1;
        end
      end
      S_CONVERT: begin
        if (cnt_term) begin
          state_d = S_TURN;
          idx_d   = '0;
        end else begin
          cnt_en     = 1'b1;
          convert_d  = 1'b1;
          data_oe_d  = 1'b1;
          data_out_d = DATA_W'(cnt_count + CNT_W'(1));
        end
      end
      S_TURN: begin
        state_d  = S_SETTLE;
        idx_d    = '0;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(C_SETTLE - 1);
        read_d   = read_sel(IDX_W'(0));
      end
      S_SETTLE: begin
        if (cnt_term) begin
          state_d     = S_HOLD;
          pix_data_d  = data_in;
          pix_idx_d   = idx_q;
          pix_valid_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
          read_d = read_sel(idx_q);
        end
      end
      S_HOLD: begin
        if (pix_valid_q && pix_ready) begin
          pix_valid_d = 1'b0;
          if (idx_q == IDX_W'(NUM_PIX - 1)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            idx_d    = idx_q + IDX_W'(1);
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(C_SETTLE - 1);
            read_d   = read_sel(idx_q + IDX_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      pix_reset_q  <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= '0;
      data_oe_q    <= 1'b0;
      data_out_q   <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      pix_reset_q  <= pix_reset_d;
      convert_q    <= convert_d;
      read_q       <= read_d;
      data_oe_q    <= data_oe_d;
      data_out_q   <= data_out_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign PIX_RESET  = pix_reset_q;
  assign CONVERT    = convert_q;
  assign READ       = read_q;
  assign data_oe    = data_oe_q;
  assign data_out   = data_out_q;
  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_ctrl.sv
// tb/tb_pixel_ctrl.sv - randomized self-checking bench for pixel_ctrl
module tb_pixel_ctrl;

  localparam int C_ERASE  = 5;
  localparam int C_EXPOSE = 255;
  localparam int C_SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ERASE, EXPOSE, PIX_RESET, CONVERT;
  logic [3:0] READ;
  logic       data_oe;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic [7:0] pix_data;
  logic [1:0] pix_idx;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  code_arr [4];
  logic [7:0]  bus_noise = 8'h5A;
  logic [7:0]  last_pd = 8'h00;
  logic [1:0]  last_pi = 2'd0;
  logic [28:0] exp_q [$];
  bit          rdy_q [$];
  bit          st_q  [$];

  wire [28:0] obs = {ERASE, EXPOSE, PIX_RESET, CONVERT, READ, data_oe, data_out,
                     pix_data, pix_idx, pix_valid, frame_done};

  pixel_ctrl #(.C_ERASE(C_ERASE), .C_EXPOSE(C_EXPOSE), .C_SETTLE(C_SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .ERASE(ERASE), .EXPOSE(EXPOSE), .PIX_RESET(PIX_RESET), .CONVERT(CONVERT),
    .READ(READ), .data_oe(data_oe), .data_out(data_out), .data_in(data_in),
    .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Array/bus model: the selected pixel drives its latched code, otherwise
  // the controller's own drive or an undriven-bus pattern is seen.
  always_comb begin
    data_in = bus_noise;
    if (data_oe) data_in = data_out;
    for (int i = 0; i < 4; i++) if (READ[i]) data_in = code_arr[i];
  end

  // Bus mutual exclusion and one-hot READ, every cycle of every test.
  always @(negedge clk) begin
    vectors++;
    if ((int'(ERASE) + int'(EXPOSE) + int'(data_oe) + int'(|READ)) > 1 ||
        !$onehot0(READ) || (data_oe && |READ)) begin
      miscompares++;
      $display("FAIL excl t=%0t: ERASE=%b EXPOSE=%b data_oe=%b READ=%b required exclusive",
               $time, ERASE, EXPOSE, data_oe, READ);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [28:0] pack(input bit er, input bit ex, input bit pr, input bit cv,
                                       input logic [3:0] rd, input bit oe, input logic [7:0] dout,
                                       input logic [7:0] pd, input logic [1:0] pi,
                                       input bit pv, input bit fd);
    return {er, ex, pr, cv, rd, oe, dout, pd, pi, pv, fd};
  endfunction

  task automatic push(input logic [28:0] e, input bit r, input bit s);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    st_q.push_back(s);
  endtask

  // Builds the cycle-by-cycle expected frame from the phase lengths, then
  // replays it. mode 0: ready high except stalls; mode 1: random ready and
  // random hold lengths. abort_at >= 0 pulses reset at that cycle.
  task automatic run_frame(input string name, input bit rand_codes, input int mode,
                           input int stall_pix, input int stall_len,
                           input bit hold_start, input int abort_at);
    logic [7:0] pd;
    logic [1:0] pi;
    int hl;
    bit aborted;
    bit r;
    exp_q.delete(); rdy_q.delete(); st_q.delete();
    if (rand_codes) begin
      for (int i = 0; i < 4; i++) code_arr[i] = 8'($urandom);
    end else begin
      code_arr[0] = 8'h12; code_arr[1] = 8'h80; code_arr[2] = 8'h00; code_arr[3] = 8'hFF;
    end
    bus_noise = 8'($urandom);
    pd = last_pd;
    pi = last_pi;

    for (int i = 0; i < C_ERASE; i++)
      push(pack(1,0,1,0,4'h0,0,8'h00,pd,pi,0,0), mode == 0 ? 1'b1 : 1'($urandom), hold_start | 1'($urandom));
    for (int i = 0; i < C_EXPOSE; i++)
      push(pack(0,1,0,0,4'h0,0,8'h00,pd,pi,0,0), mode == 0 ? 1'b1 : 1'($urandom), hold_start | 1'($urandom));
    for (int k = 0; k < 256; k++)
      push(pack(0,0,0,1,4'h0,1,8'(k),pd,pi,0,0), mode == 0 ? 1'b1 : 1'($urandom), hold_start | 1'($urandom));
    push(pack(0,0,0,0,4'h0,0,8'h00,pd,pi,0,0), mode == 0 ? 1'b1 : 1'($urandom), hold_start | 1'($urandom));
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < C_SETTLE; s++)
        push(pack(0,0,0,0,4'(1 << p),0,8'h00,pd,pi,0,0), mode == 0 ? 1'b1 : 1'($urandom),
             hold_start | 1'($urandom));
      hl = (mode == 0) ? 1 : int'($urandom_range(1, 4));
      if (p == stall_pix) hl = stall_len + 1;
      pd = code_arr[p];
      pi = 2'(p);
      for (int h = 0; h < hl; h++)
        push(pack(0,0,0,0,4'h0,0,8'h00,pd,pi,1,0), h == hl - 1, hold_start | 1'($urandom));
    end
    push(pack(0,0,0,0,4'h0,0,8'h00,pd,pi,0,1), 1'b1, hold_start);
    if (hold_start) begin
      push(pack(1,0,1,0,4'h0,0,8'h00,pd,pi,0,0), 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < 3; i++) push(pack(0,0,0,0,4'h0,0,8'h00,pd,pi,0,0), 1'b1, 1'b0);
    end

    start = 1'b1;
    @(negedge clk);
    aborted = 1'b0;
    for (int k = 0; k < exp_q.size() && !aborted; k++) begin
      vectors++;
      if (obs !== exp_q[k]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs, exp_q[k]);
      end
      start = st_q[k];
      r = rdy_q[k];
      pix_ready = r;
      if (k == abort_at) begin
        aborted = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
          vectors++;
          if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL %s post-reset cycle %0d: got %h expected 0", name, i, obs);
          end
          pix_ready = 1'($urandom);
          @(negedge clk);
        end
        last_pd = 8'h00;
        last_pi = 2'd0;
      end else begin
        @(negedge clk);
      end
    end
    if (!aborted) begin
      last_pd = pd;
      last_pi = pi;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    reset_n = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (obs !== 29'h0) begin
        miscompares++;
        $display("FAIL idle_after_reset: got %h expected 0", obs);
      end
    end
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 1'b0, 0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_frame("stall", 1'b0, 0, 1, 10, 1'b0, -1);
  endtask

  task automatic test_random_frames();
    repeat (3) run_frame("random", 1'b1, 1, -1, 0, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    run_frame("abort", 1'b1, 1, -1, 0, 1'b0, C_ERASE + C_EXPOSE + 100);
  endtask

  task automatic test_start_held();
    run_frame("held", 1'b1, 1, -1, 0, 1'b1, -1);
    reset_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    last_pd = 8'h00;
    last_pi = 2'd0;
    vectors++;
    if (obs !== 29'h0) begin
      miscompares++;
      $display("FAIL held_cleanup: got %h expected 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 1'b1, 0, -1, 0, 1'b0, -1);
    run_frame("b2b_b", 1'b1, 1, 2, 3, 1'b0, -1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_frames();
    test_mid_reset();
    test_start_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
